mux_4to1_arb: RTL and testbench
===============================

MUX_4TO1_ARB -- requirements
Module: mux_4to1_arb

Interface
REQ-001 SHALL provide parameter MAX_BURST, default 4: maximum consecutive transfers per grant when burst lock is compiled in; legal range 1..15.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port req  input  4  request per source; bit 0 maps to mux input a, bit 1 to b, bit 2 to c, bit 3 to d.
REQ-005 SHALL provide port ready  input  1  downstream accepts the muxed word this cycle.
REQ-006 SHALL provide port sel  output  2  select code for the downstream 4:1 mux (00=a, 01=b, 10=c, 11=d).
REQ-007 SHALL provide port en  output  1  enable for the downstream 4:1 mux; high only while a grant is active.
REQ-008 SHALL provide port gnt  output  4  one-hot grant, bit index equal to sel while en=1; all zero otherwise.
REQ-009 SHALL provide port valid  output  1  muxed word is valid for downstream; identical to en.

Function
REQ-010 SHALL implement two states: IDLE (en=0, gnt=0000) and GRANT (en=1, gnt one-hot).
REQ-011 SHALL keep a 2-bit priority pointer ptr; round-robin search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-012 IDLE: if req!=0 at a rising edge, SHALL register the first requesting index in search order into sel, set gnt, and enter GRANT; outputs visible one cycle after req is sampled.
REQ-013 IDLE with req=0000: SHALL stay in IDLE, sel holds its last value, ptr unchanged.
REQ-014 A transfer SHALL occur on a rising edge where valid=1 and ready=1.
REQ-015 GRANT: sel, gnt, en and valid SHALL stay stable until a transfer, even if the granted req bit drops.
REQ-016 On release, SHALL set ptr to sel+1 (wrap 3->0).
REQ-017 On release, if any req bit is set, SHALL re-arbitrate in the same edge using the updated ptr and remain in GRANT with no idle bubble; otherwise SHALL return to IDLE.
REQ-018 Re-arbitration after release SHALL regrant the same source only if it is the sole requester.
REQ-019 SHALL keep a burst counter, cleared on every new grant and incremented on each transfer.
REQ-020 Simultaneous req=1111 from reset SHALL produce grant order 0,1,2,3,0,... (without lock).

Reset
REQ-021 rst_n=0 SHALL asynchronously force state=IDLE, sel=00, en=0, gnt=0000, valid=0, ptr=00, burst counter=0.
REQ-022 Reset asserted mid-GRANT SHALL abort the grant immediately; the in-flight word is not transferred.
REQ-023 After rst_n deasserts, the first arbitration SHALL occur on the next rising edge with ptr=00.

Configuration
REQ-024 Macro MUX_4TO1_ARB_LOCK_EN SHALL select burst lock.
REQ-025 MUX_4TO1_ARB_LOCK_EN defined: on transfer, if the granted req bit is still 1 and burst count+1 < MAX_BURST, SHALL keep the same grant (no release, ptr unchanged); otherwise release per REQ-016/017.
REQ-026 MUX_4TO1_ARB_LOCK_EN undefined: every transfer SHALL release the grant; MAX_BURST is ignored and the burst counter may be optimised away.

Verification
REQ-027 Reset then req=0100, ready=1: one cycle later sel=10, gnt=0100, en=valid=1; after transfer with req=0000, next cycle en=0, ptr=11.
REQ-028 req=1111, ready=1 constantly, lock undefined: sel sequence 00,01,10,11,00 on consecutive cycles, no gaps.
REQ-029 Grant on source 1, ready=0 for 5 cycles while req[1] drops and req[3] rises: sel=01 held all 5 cycles; after ready=1 edge, sel=11.
REQ-030 ptr=11, req=1001: grant goes to index 3 first, then 0 (wrap-around).
REQ-031 Lock defined, MAX_BURST=4, req=0011, ready=1: sel=00 for 4 transfers, then sel=01 for 4 transfers.
REQ-032 rst_n pulled low mid-GRANT between clock edges: en, valid, gnt, sel go to 0 without waiting for clk; next grant after release starts from ptr=00.

Source files
------------

// File: rtl/mux_4to1_arb_if.sv
// mux_4to1_arb_if
// Bundles the request/ready inputs and the select/grant outputs of the
// 4-source round-robin arbiter that steers a downstream 4:1 mux.
//   req   [3:0] : request per source (bit0=a, bit1=b, bit2=c, bit3=d)
//   ready       : downstream accepts the muxed word this cycle
//   sel   [1:0] : downstream mux select (00=a .. 11=d)
//   en          : downstream mux enable, high while a grant is active
//   gnt   [3:0] : one-hot grant, bit index equals sel while en=1
//   valid       : muxed word valid, identical to en
// Modports: master = requester/downstream side, slave = arbiter side.
interface mux_4to1_arb_if;
  logic [3:0] req;
  logic       ready;
  logic [1:0] sel;
  logic       en;
  logic [3:0] gnt;
  logic       valid;

  modport master (output req, output ready,
                  input  sel, input en, input gnt, input valid);
  modport slave  (input  req, input ready,
                  output sel, output en, output gnt, output valid);
endinterface

// File: rtl/mux_4to1_arb.sv
// mux_4to1_arb
// Round-robin arbiter that drives the select/enable of a downstream 4:1 mux.
// A grant is held until the downstream accepts the word (valid && ready);
// on release the priority pointer moves past the released source and, if
// anything is still requesting, a new grant is issued on the same edge.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mux_4to1_arb_if.slave (req, ready in; sel, en, gnt, valid out)
// Parameter:
//   MAX_BURST : transfers per grant when burst lock is built in (1..15)
// Build option:
//   MUX_4TO1_ARB_LOCK_EN : when defined, a source that keeps requesting
//   retains its grant for up to MAX_BURST consecutive transfers.
module mux_4to1_arb #(
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_4to1_arb_if.slave   bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // Counter saturates here so it can never wrap inside a long grant.
  localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

  logic [0:0] state_reg, state_next;
  logic [1:0] sel_reg, sel_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] burst_reg, burst_next;

  logic       any_req;
  logic       transfer;
  logic       keep_grant;
  logic       grant_active;
  logic [1:0] rel_ptr;
  logic [1:0] pick_idle;
  logic [1:0] pick_rel;

  // First requester in the order p, p+1, p+2, p+3 (mod 4). Scanning from
  // the farthest offset down lets the nearest hit overwrite the result.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] res;
    res = p;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  assign any_req   = |bus.req;
  assign transfer  = (state_reg == ST_GRANT) && bus.ready;
  assign rel_ptr   = sel_reg + 2'd1;
  assign pick_idle = rr_pick(bus.req, ptr_reg);
  // Re-arbitration on release already uses the advanced pointer, so the
  // released source wins again only when it is the sole requester.
  assign pick_rel  = rr_pick(bus.req, rel_ptr);

`ifdef MUX_4TO1_ARB_LOCK_EN
  assign keep_grant = bus.req[sel_reg] &&
                      (({1'b0, burst_reg} + 5'd1) < 5'(MAX_BURST));
`else
  assign keep_grant = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    burst_next = burst_reg;
    case (state_reg)
      ST_IDLE: begin
        if (any_req) begin
          state_next = ST_GRANT;
          sel_next   = pick_idle;
          burst_next = 4'd0;
        end
      end
      ST_GRANT: begin
        if (transfer) begin
          if (keep_grant) begin
            burst_next = (burst_reg == BURST_CAP) ? burst_reg : burst_reg + 4'd1;
          end else begin
            ptr_next = rel_ptr;
            if (any_req) begin
              sel_next   = pick_rel;
              burst_next = 4'd0;
            end else begin
              state_next = ST_IDLE;
              burst_next = (burst_reg == BURST_CAP) ? burst_reg : burst_reg + 4'd1;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      sel_reg   <= 2'd0;
      ptr_reg   <= 2'd0;
      burst_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      burst_reg <= burst_next;
    end
  end

  // Outputs decode straight from registered state, so an asynchronous reset
  // clears them without waiting for a clock edge.
  assign grant_active = (state_reg == ST_GRANT);
  assign bus.en       = grant_active;
  assign bus.valid    = grant_active;
  assign bus.sel      = sel_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_gnt
      assign bus.gnt[gi] = grant_active && (sel_reg == 2'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_mux_4to1_arb.sv
module tb_mux_4to1_arb;

  localparam int MB = 4;

`ifdef MUX_4TO1_ARB_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_4to1_arb_if bus_if ();

  mux_4to1_arb #(.MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: source currently granted (or none), rotating pointer,
  // transfers done in the current grant.
  int m_busy;
  int m_sel;
  int m_ptr;
  int m_burst;

  function automatic int first_req(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return p;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rd);
    if (m_busy == 0) begin
      if (r != 4'd0) begin
        m_sel = first_req(r, m_ptr);
        m_busy = 1;
        m_burst = 0;
      end
    end else if (rd) begin
      if (LOCK && r[m_sel] && (m_burst + 1 < MB)) begin
        m_burst = m_burst + 1;
      end else begin
        m_ptr = (m_sel + 1) % 4;
        if (r != 4'd0) begin
          m_sel = first_req(r, m_ptr);
          m_burst = 0;
        end else begin
          m_busy = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.req = 4'd0;
    bus_if.ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_busy = 0; m_sel = 0; m_ptr = 0; m_burst = 0;
  endtask

  // Apply inputs, let one rising edge pass, return 1 time unit after it.
  task automatic step(input logic [3:0] r, input logic rd);
    bus_if.req = r;
    bus_if.ready = rd;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step(4'b1111, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.sel !== 2'b00) begin errors++; $display("FAIL reset_sel got=%b exp=00", bus_if.sel); end
    checks++; if (bus_if.en !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", bus_if.en); end
    checks++; if (bus_if.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", bus_if.gnt); end
    checks++; if (bus_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus_if.valid); end
    do_reset();
  endtask

  task automatic test_single();
    logic [1:0] exp;
    do_reset();
    step(4'b0100, 1'b1);
    checks++; if (bus_if.sel !== 2'b10) begin errors++; $display("FAIL single_sel got=%b exp=10", bus_if.sel); end
    checks++; if (bus_if.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", bus_if.gnt); end
    checks++; if (bus_if.en !== 1'b1 || bus_if.valid !== 1'b1) begin errors++; $display("FAIL single_en got=%b/%b exp=1/1", bus_if.en, bus_if.valid); end
    step(4'b0000, 1'b1);
    checks++; if (bus_if.en !== 1'b0 || bus_if.gnt !== 4'b0000) begin errors++; $display("FAIL single_release en=%b gnt=%b exp=0/0000", bus_if.en, bus_if.gnt); end
    // ptr is now 3: req=1001 must pick d first, then wrap to a.
    step(4'b1001, 1'b1);
    checks++; if (bus_if.sel !== 2'b11) begin errors++; $display("FAIL wrap_first got=%b exp=11", bus_if.sel); end
    for (int i = 1; i <= 5; i++) begin
      step(4'b1001, 1'b1);
      if (LOCK) exp = (i < MB) ? 2'd3 : 2'd0;
      else      exp = (i % 2 == 1) ? 2'd0 : 2'd3;
      checks++; if (bus_if.sel !== exp) begin errors++; $display("FAIL wrap_seq[%0d] got=%b exp=%b", i, bus_if.sel, exp); end
    end
  endtask

  task automatic test_rr_all();
    logic [1:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 1'b1);
      exp = LOCK ? 2'((i / MB) % 4) : 2'(i % 4);
      checks++; if (bus_if.sel !== exp || bus_if.en !== 1'b1) begin errors++; $display("FAIL rr_all[%0d] sel=%b en=%b exp=%b/1", i, bus_if.sel, bus_if.en, exp); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    step(4'b0010, 1'b0);
    checks++; if (bus_if.sel !== 2'b01) begin errors++; $display("FAIL hold_grant got=%b exp=01", bus_if.sel); end
    for (int i = 0; i < 5; i++) begin
      step(4'b1000, 1'b0);
      checks++; if (bus_if.sel !== 2'b01 || bus_if.gnt !== 4'b0010 || bus_if.valid !== 1'b1) begin errors++; $display("FAIL hold[%0d] sel=%b gnt=%b valid=%b exp=01/0010/1", i, bus_if.sel, bus_if.gnt, bus_if.valid); end
    end
    step(4'b1000, 1'b1);
    checks++; if (bus_if.sel !== 2'b11 || bus_if.gnt !== 4'b1000) begin errors++; $display("FAIL hold_next sel=%b gnt=%b exp=11/1000", bus_if.sel, bus_if.gnt); end
  endtask

  task automatic test_lock();
    logic [1:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b0011, 1'b1);
      exp = LOCK ? 2'((i / MB) % 2) : 2'(i % 2);
      checks++; if (bus_if.sel !== exp) begin errors++; $display("FAIL lock[%0d] got=%b exp=%b", i, bus_if.sel, exp); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0100, 1'b0);
    checks++; if (bus_if.sel !== 2'b10 || bus_if.en !== 1'b1) begin errors++; $display("FAIL areset_pre sel=%b en=%b exp=10/1", bus_if.sel, bus_if.en); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.en !== 1'b0 || bus_if.valid !== 1'b0) begin errors++; $display("FAIL areset_en en=%b valid=%b exp=0/0", bus_if.en, bus_if.valid); end
    checks++; if (bus_if.gnt !== 4'b0000 || bus_if.sel !== 2'b00) begin errors++; $display("FAIL areset_out gnt=%b sel=%b exp=0000/00", bus_if.gnt, bus_if.sel); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.req = 4'b1111;
    bus_if.ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus_if.sel !== 2'b00 || bus_if.en !== 1'b1) begin errors++; $display("FAIL areset_restart sel=%b en=%b exp=00/1", bus_if.sel, bus_if.en); end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       rd;
    logic [3:0] exp_gnt;
    int         was_busy;
    int         txn;
    txn = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      r  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'd0;
      rd = ($urandom_range(0, 2) != 0);
      was_busy = m_busy;
      model_edge(r, rd);
      step(r, rd);
      if (was_busy != 0 && rd) begin
        txn++;
        $display("txn %0d: req=%b next_sel=%0d next_en=%0d", txn, r, bus_if.sel, bus_if.en);
      end
      exp_gnt = (m_busy != 0) ? (4'b0001 << m_sel) : 4'b0000;
      checks++; if (bus_if.sel !== 2'(m_sel)) begin errors++; $display("FAIL rand_sel[%0d] got=%0d exp=%0d", i, bus_if.sel, m_sel); end
      checks++; if (bus_if.en !== 1'(m_busy) || bus_if.valid !== 1'(m_busy)) begin errors++; $display("FAIL rand_en[%0d] en=%b valid=%b exp=%0d", i, bus_if.en, bus_if.valid, m_busy); end
      checks++; if (bus_if.gnt !== exp_gnt) begin errors++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", i, bus_if.gnt, exp_gnt); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.req = 4'd0;
    bus_if.ready = 1'b0;
    m_busy = 0; m_sel = 0; m_ptr = 0; m_burst = 0;
    do_reset();
    test_reset();
    test_single();
    test_rr_all();
    test_hold();
    test_lock();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
